// File: rtl/enemy_hit_tracker.sv
// enemy_hit_tracker: per-frame player/enemy collision detection with a lives
// counter, post-hit invulnerability window (with blink), and game-over latch.
module enemy_hit_tracker #(
  parameter int LIVES_INIT    = 3,   // 1..7
  parameter int INVULN_FRAMES = 60,  // 1..255
  parameter int BLINK_BIT     = 3    // 0..7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] ball_X,
  input  logic [9:0] ball_Y,
  input  logic [9:0] ball_S,
  input  logic [9:0] enemy_X,
  input  logic [9:0] enemy_Y,
  input  logic [9:0] enemy_S,
  input  logic       restart,
  output logic [2:0] lives,
  output logic       hit_pulse,
  output logic       invuln,
  output logic       flash,
  output logic       game_over
);

  typedef enum logic [1:0] {PLAY, INVULN, DEAD} state_t;

  state_t      state_q;
  logic [2:0]  lives_q;
  logic [7:0]  inv_cnt_q;
  logic        hit_q;

  logic [10:0] bx, by, bs, ex, ey, es;
  logic [10:0] dx, dy, lim;
  logic        overlap;

  // Bounding-box overlap in 11 bits so neither |diff| nor the size sum can wrap
  always_comb begin
    bx      = {1'b0, ball_X};
    by      = {1'b0, ball_Y};
    bs      = {1'b0, ball_S};
    ex      = {1'b0, enemy_X};
    ey      = {1'b0, enemy_Y};
    es      = {1'b0, enemy_S};
    dx      = (bx >= ex) ? (bx - ex) : (ex - bx);
    dy      = (by >= ey) ? (by - ey) : (ey - by);
    lim     = bs + es;
    // Touching edges (distance == lim) is deliberately not a hit
    overlap = (dx < lim) && (dy < lim);
  end

  // Game FSM: hits only count in PLAY; INVULN runs exactly INVULN_FRAMES frames
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= PLAY;
      lives_q   <= 3'(LIVES_INIT);
      inv_cnt_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (overlap) begin
            hit_q <= 1'b1;
            if (lives_q > 3'd1) begin
              lives_q   <= lives_q - 3'd1;
              inv_cnt_q <= 8'(INVULN_FRAMES - 1);
              state_q   <= INVULN;
            end else begin
              lives_q <= '0;
              state_q <= DEAD;
            end
          end
        end
        INVULN: begin
          if (inv_cnt_q == '0) state_q <= PLAY;
          else                 inv_cnt_q <= inv_cnt_q - 8'd1;
        end
        DEAD: begin
          if (restart) begin
            lives_q <= 3'(LIVES_INIT);
            state_q <= PLAY;
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  // Outputs are straight decodes of registered state
  assign lives     = lives_q;
  assign hit_pulse = hit_q;
  assign invuln    = (state_q == INVULN);
  assign flash     = (state_q == INVULN) && inv_cnt_q[BLINK_BIT];
  assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Bench for enemy_hit_tracker: frame-level behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_enemy_hit_tracker;

  localparam int L  = 3;
  localparam int N  = 60;
  localparam int BB = 3;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] ball_X, ball_Y, ball_S, enemy_X, enemy_Y, enemy_S;
  logic       restart;
  logic [2:0] lives;
  logic       hit_pulse, invuln, flash, game_over;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  enemy_hit_tracker #(.LIVES_INIT(L), .INVULN_FRAMES(N), .BLINK_BIT(BB)) dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .ball_X(ball_X), .ball_Y(ball_Y), .ball_S(ball_S),
    .enemy_X(enemy_X), .enemy_Y(enemy_Y), .enemy_S(enemy_S),
    .restart(restart),
    .lives(lives), .hit_pulse(hit_pulse), .invuln(invuln),
    .flash(flash), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = playing, 1 = immune, 2 = dead; m_el = frames elapsed since hit
  int m_lives, m_mode, m_el;
  bit m_hit;

  function automatic bit ovl();
    int dx, dy, lim;
    dx  = (int'(ball_X) > int'(enemy_X)) ? int'(ball_X) - int'(enemy_X) : int'(enemy_X) - int'(ball_X);
    dy  = (int'(ball_Y) > int'(enemy_Y)) ? int'(ball_Y) - int'(enemy_Y) : int'(enemy_Y) - int'(ball_Y);
    lim = int'(ball_S) + int'(enemy_S);
    return (dx < lim) && (dy < lim);
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    int nl, nm, ne;
    bit nh;
    if (Reset) begin
      m_lives <= L; m_mode <= 0; m_el <= 0; m_hit <= 1'b0;
    end else begin
      nl = m_lives; nm = m_mode; ne = m_el; nh = 1'b0;
      if (m_mode == 0) begin
        if (ovl()) begin
          nl = m_lives - 1; nh = 1'b1;
          if (nl == 0) nm = 2;
          else begin nm = 1; ne = 0; end
        end
      end else if (m_mode == 1) begin
        ne = m_el + 1;
        if (ne == N) nm = 0;
      end else begin
        if (restart) begin nl = L; nm = 0; end
      end
      m_lives <= nl; m_mode <= nm; m_el <= ne; m_hit <= nh;
    end
  end

  function automatic int m_flash();
    if (m_mode != 1) return 0;
    return ((N - 1 - m_el) >> BB) & 1;
  endfunction

  // Per-cycle comparison, away from the active edge
  always @(negedge frame_clk) begin
    if (chk_en) begin
      chk("cmp_lives",     int'(lives),     m_lives);
      chk("cmp_hit_pulse", int'(hit_pulse), int'(m_hit));
      chk("cmp_invuln",    int'(invuln),    int'(m_mode == 1));
      chk("cmp_flash",     int'(flash),     m_flash());
      chk("cmp_game_over", int'(game_over), int'(m_mode == 2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic setpos(input int bx, by, bs, ex, ey, es);
    ball_X  = 10'(bx); ball_Y  = 10'(by); ball_S  = 10'(bs);
    enemy_X = 10'(ex); enemy_Y = 10'(ey); enemy_S = 10'(es);
  endtask

  task automatic all_flags(input string tag, input int l, input int h, input int i, input int f, input int g);
    chk({tag, "_lives"}, int'(lives), l);
    chk({tag, "_hit"},   int'(hit_pulse), h);
    chk({tag, "_inv"},   int'(invuln), i);
    chk({tag, "_flash"}, int'(flash), f);
    chk({tag, "_go"},    int'(game_over), g);
  endtask

  initial begin
    Reset = 1'b1; restart = 1'b0;
    setpos(100, 100, 4, 320, 240, 32);
    #12 Reset = 1'b0;
    step(1);
    chk_en = 1'b1;
    all_flags("reset", 3, 0, 0, 0, 0);
    step(10);
    all_flags("idle10", 3, 0, 0, 0, 0);

    // First hit: dx=20 < 36
    setpos(320, 240, 4, 340, 240, 32);
    step(1);
    all_flags("hit1", 2, 1, 1, 1, 0);   // counter starts at 59 -> bit3 set
    chk("model_pin_hit1", m_lives, 2);
    step(1);
    chk("hit1_pulse_end", int'(hit_pulse), 0);
    step(3);
    chk("flash_off_cnt55", int'(flash), 0);
    // restart during immunity is ignored
    step(7); restart = 1'b1;
    step(10); restart = 1'b0;
    step(38);                            // 59 edges after hit: last immune frame
    chk("inv_last", int'(invuln), 1);
    chk("lives_last", int'(lives), 2);
    step(1);                             // 60 edges: back to PLAY
    chk("inv_exit", int'(invuln), 0);
    chk("lives_exit", int'(lives), 2);
    step(1);                             // 61 edges: held overlap hits again
    chk("hit2_lives", int'(lives), 1);
    chk("hit2_pulse", int'(hit_pulse), 1);
    chk("model_pin_hit2", m_lives, 1);

    // Separate and ride out immunity
    setpos(100, 100, 4, 320, 240, 32);
    step(62);
    chk("play_again", int'(invuln), 0);

    // Touching edges: dx == lim == 36 -> no hit
    setpos(304, 240, 4, 340, 240, 32);
    step(3);
    chk("edge_dx36", int'(lives), 1);
    // 10-bit difference wrap: dx=995, lim=40 -> no hit
    setpos(5, 240, 8, 1000, 240, 32);
    step(3);
    chk("wrap_dx", int'(lives), 1);
    // dx=35 -> fatal hit
    setpos(305, 240, 4, 340, 240, 32);
    step(1);
    all_flags("dead", 0, 1, 0, 0, 1);
    chk("model_pin_dead", m_mode, 2);
    step(1);
    chk("dead_pulse_end", int'(hit_pulse), 0);
    step(20);
    all_flags("dead_hold", 0, 0, 0, 0, 1);
    restart = 1'b1;
    step(1);
    all_flags("restart", 3, 0, 0, 0, 0);
    restart = 1'b0;
    setpos(100, 100, 4, 320, 240, 32);
    step(2);

    // Size-sum wrap: 1000+30=1030 (would be 6 in 10 bits), dx=10 -> hit
    setpos(100, 100, 1000, 110, 100, 30);
    step(1);
    chk("sumwrap_lives", int'(lives), 2);
    chk("sumwrap_hit", int'(hit_pulse), 1);
    setpos(100, 100, 4, 320, 240, 32);
    step(61);
    // dy == 36 -> no hit; dy == 35 -> hit
    setpos(320, 240, 4, 320, 276, 32);
    step(2);
    chk("edge_dy36", int'(lives), 2);
    setpos(320, 240, 4, 320, 275, 32);
    step(1);
    chk("dy35_lives", int'(lives), 1);
    chk("dy35_inv", int'(invuln), 1);

    // Asynchronous reset mid-immunity, between edges
    setpos(100, 100, 4, 320, 240, 32);
    step(5);
    #3 Reset = 1'b1;
    #1 all_flags("async_rst", 3, 0, 0, 0, 0);
    step(1);
    Reset = 1'b0;
    step(3);
    all_flags("post_rst", 3, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
